// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift/rotate sequencer: accepts one command in IDLE, shifts the
// accumulator one bit per clock, then pulses done with the registered result.
module shift_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [31:0]      shift_amount,
  output logic             busy,
  output logic             done,
  output logic             illegal_op,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_SHL  = 3'd0;
  localparam logic [2:0] OP_SHR  = 3'd1;
  localparam logic [2:0] OP_SHRA = 3'd2;
  localparam logic [2:0] OP_ROL  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             ill_q, ill_d;
  logic [WIDTH-1:0] step;

  // One-bit move of the accumulator for the latched operation.
  always_comb begin
    step = acc_q;
    case (op_q)
      OP_SHL:  step = {acc_q[WIDTH-2:0], 1'b0};
      OP_SHR:  step = {1'b0, acc_q[WIDTH-1:1]};
      OP_SHRA: step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      OP_ROL:  step = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]};
      OP_ROR:  step = {acc_q[0], acc_q[WIDTH-1:1]};
      default: step = acc_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    ill_d    = ill_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          ill_d = 1'b0;
          acc_d = data_in;
          cnt_d = 5'd0;
          case (op)
            OP_SHL, OP_SHR, OP_SHRA: begin
              // Distances of 32 or more collapse straight to the fill value.
              if (|shift_amount[31:5])
                acc_d = (op == OP_SHRA) ? {WIDTH{data_in[WIDTH-1]}} : '0;
              else
                cnt_d = shift_amount[4:0];
            end
            OP_ROL, OP_ROR: cnt_d = shift_amount[4:0];
            default:        ill_d = 1'b1;
          endcase
          if (cnt_d == 5'd0) begin
            state_d  = S_DONE;
            result_d = acc_d;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        acc_d = step;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d  = S_DONE;
          result_d = step;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      cnt_q    <= 5'd0;
      op_q     <= 3'd0;
      ill_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      ill_q    <= ill_d;
      result_q <= result_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign illegal_op = (state_q == S_DONE) && ill_q;
  assign result     = result_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed cases plus random commands
// compared against an arithmetic reference model.
module tb_shift_seq_ctrl;

  logic        clock;
  logic        clear;
  logic        start;
  logic [2:0]  op;
  logic [31:0] data_in;
  logic [31:0] shift_amount;
  logic        busy;
  logic        done;
  logic        illegal_op;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_exp = 32'h0;

  shift_seq_ctrl #(.WIDTH(32)) dut (
    .clock(clock),
    .clear(clear),
    .start(start),
    .op(op),
    .data_in(data_in),
    .shift_amount(shift_amount),
    .busy(busy),
    .done(done),
    .illegal_op(illegal_op),
    .result(result)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference: whole-word arithmetic on the operation's meaning.
  function automatic void model(input logic [2:0] o, input logic [31:0] d,
                                input logic [31:0] a, output logic [31:0] r,
                                output int k, output bit ill);
    int rot;
    bit big;
    rot = int'(a % 32);
    big = (a >= 32);
    ill = 1'b0;
    k   = 0;
    case (o)
      3'd0: begin r = big ? 32'h0 : d << a; k = big ? 0 : int'(a); end
      3'd1: begin r = big ? 32'h0 : d >> a; k = big ? 0 : int'(a); end
      3'd2: begin r = big ? {32{d[31]}} : 32'($signed(d) >>> a); k = big ? 0 : int'(a); end
      3'd3: begin r = (rot == 0) ? d : ((d << rot) | (d >> (32 - rot))); k = rot; end
      3'd4: begin r = (rot == 0) ? d : ((d >> rot) | (d << (32 - rot))); k = rot; end
      default: begin r = d; ill = 1'b1; end
    endcase
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the idle
  // cycle that follows DONE. inject_cyc>0 re-asserts start with junk operands.
  task automatic run_cmd(input logic [2:0] o, input logic [31:0] d,
                         input logic [31:0] a, input int inject_cyc,
                         input string name);
    logic [31:0] exp_r;
    int          k;
    bit          ill;
    int          done_cyc;
    int          busy_cnt;
    model(o, d, a, exp_r, k, ill);
    op = o; data_in = d; shift_amount = a; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    op = 3'($urandom); data_in = $urandom; shift_amount = $urandom;
    done_cyc = 0;
    busy_cnt = 0;
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      @(negedge clock);
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = c;
        checks++;
        if (result !== exp_r) begin
          errors++;
          $display("FAIL %s result: got %h expected %h", name, result, exp_r);
        end
        checks++;
        if (illegal_op !== ill) begin
          errors++;
          $display("FAIL %s illegal_op: got %b expected %b", name, illegal_op, ill);
        end
      end else begin
        checks++;
        if (result !== last_exp || illegal_op !== 1'b0) begin
          errors++;
          $display("FAIL %s hold cycle %0d: result %h ill %b expected %h ill 0",
                   name, c, result, illegal_op, last_exp);
        end
      end
      start = (c == inject_cyc);
    end
    start = 1'b0;
    checks++;
    if (done_cyc != k + 1) begin
      errors++;
      $display("FAIL %s done cycle: got %0d expected %0d", name, done_cyc, k + 1);
    end
    checks++;
    if (busy_cnt != k + 1) begin
      errors++;
      $display("FAIL %s busy cycles: got %0d expected %0d", name, busy_cnt, k + 1);
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== exp_r) begin
      errors++;
      $display("FAIL %s after done: busy %b done %b result %h expected 0 0 %h",
               name, busy, done, result, exp_r);
    end
    last_exp = exp_r;
    $display("cmd %s op=%0d data=%h amt=%0d -> result=%h done@%0d ill=%b",
             name, o, d, a, exp_r, done_cyc, ill);
  endtask

  task automatic test_reset();
    clear = 1'b1; start = 1'b0; op = 3'd0; data_in = 32'h0; shift_amount = 32'h0;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || illegal_op !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset: busy %b done %b ill %b result %h expected all 0",
               busy, done, illegal_op, result);
    end
    clear = 1'b0;
    last_exp = 32'h0;
    @(negedge clock);
    $display("reset done");
  endtask

  task automatic test_basic();
    run_cmd(3'd0, 32'h5,        32'd3,  0, "shl5by3");
    run_cmd(3'd2, 32'hF0000000, 32'd4,  0, "shra");
    run_cmd(3'd1, 32'hF0000000, 32'd4,  0, "shr");
    run_cmd(3'd4, 32'h00000001, 32'd1,  0, "ror1");
    run_cmd(3'd3, 32'h80000001, 32'd33, 0, "rol33");
  endtask

  task automatic test_boundaries();
    for (int o = 0; o < 5; o++)
      run_cmd(3'(o), 32'hA5C3_0F81, 32'd0, 0, "amt0");
    run_cmd(3'd0, 32'hFFFF_FFFF, 32'd40,  0, "shl40");
    run_cmd(3'd1, 32'hFFFF_FFFF, 32'd32,  0, "shr32");
    run_cmd(3'd2, 32'h80000000, 32'd100, 0, "shra100");
    run_cmd(3'd0, 32'h1,         32'd31,  0, "shl31");
  endtask

  task automatic test_illegal();
    run_cmd(3'd7, 32'h1234, 32'd5, 0, "illegal7");
    run_cmd(3'd5, 32'hBEEF, 32'd0, 0, "illegal5");
  endtask

  task automatic test_ignore_start();
    run_cmd(3'd0, 32'd6, 32'd10, 3, "shl6by10_restart");
  endtask

  task automatic test_clear_mid();
    op = 3'd0; data_in = 32'h1; shift_amount = 32'd20; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || illegal_op !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL clear_mid: busy %b done %b ill %b result %h expected all 0",
               busy, done, illegal_op, result);
    end
    clear = 1'b0;
    last_exp = 32'h0;
    $display("cmd clear_mid abandoned");
    run_cmd(3'd4, 32'h0000_00F0, 32'd4, 0, "after_clear");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  o;
      logic [31:0] d;
      logic [31:0] a;
      int          sel;
      o   = 3'($urandom_range(0, 7));
      d   = $urandom;
      sel = $urandom_range(0, 3);
      a   = (sel == 0) ? 32'($urandom_range(0, 40)) :
            (sel == 1) ? $urandom : 32'($urandom_range(0, 31));
      run_cmd(o, d, a, (i % 3 == 0) ? $urandom_range(1, 3) : 0, "random");
    end
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; op = 3'd0; data_in = 32'h0; shift_amount = 32'h0;
    test_reset();
    test_basic();
    test_boundaries();
    test_illegal();
    test_ignore_start();
    test_clear_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Multi-cycle sequencer for the ALU shift/rotate path. Takes over from the single-cycle combinational shifter on the area-reduced datapath.
- Accepts one shift/rotate command and applies a 1-bit shift per clock until the requested distance is done.
- Reports completion with a one-cycle done pulse. Sits between the control unit (start/op) and the Z-register input mux (result).

Parameters:
- WIDTH, 32, data width (fixed at 32 for this CPU; shift distance uses 5 bits)

Ports:
- clock  input  1  system clock, rising edge
- clear  input  1  synchronous, active-high reset
- start  input  1  command strobe, sampled only in IDLE
- op  input  3  000 SHL, 001 SHR, 010 SHRA, 011 ROL, 100 ROR; 101-111 illegal
- data_in  input  32  operand to shift
- shift_amount  input  32  unsigned shift distance
- busy  output  1  high in SHIFT and DONE states
- done  output  1  one-cycle completion pulse
- illegal_op  output  1  pulses with done when op was illegal
- result  output  32  registered result; holds until the next completion

Behaviour:
- Reset: on any clock edge with clear=1, state=IDLE. busy=0, done=0, illegal_op=0, result=0, internal acc=0, cnt=0.
- Reset mid-operation: clear takes priority over all other inputs and abandons the command. result returns to 0.
- States: IDLE, SHIFT, DONE. All outputs are registered or decoded from state; there is no combinational path from start to any output.
- IDLE, start=0: stay in IDLE.
- IDLE, start=1: latch op. Set acc=data_in. Set cnt per the distance rules below.
  - cnt != 0: go to SHIFT.
  - cnt == 0: go to DONE, with acc set per the distance rules below.
- Distance rules:
  - For rotates, cnt = shift_amount[4:0] (modulo 32).
  - For shifts with shift_amount < 32, cnt = shift_amount[4:0].
  - For shifts with shift_amount >= 32, cnt=0 and acc is loaded directly with the fill value: SHL/SHR give 0x00000000; SHRA gives all bits equal to data_in[31].
  - For an illegal op, cnt=0, acc=data_in, and illegal_op is flagged.
- SHIFT: each edge moves acc by one bit and decrements cnt.
  - SHL: {acc[30:0],0}
  - SHR: {0,acc[31:1]}
  - SHRA: {acc[31],acc[31:1]}
  - ROL: {acc[30:0],acc[31]}
  - ROR: {acc[0],acc[31:1]}
  - When cnt==1 at the edge, the final shift is applied and the state moves to DONE.
- DONE: done=1 for exactly one cycle, with result=acc captured on the same edge that entered DONE. illegal_op=1 in this cycle if flagged. The next edge returns to IDLE.
- Latency: with k = effective cnt, done is high in cycle k+1 after the accepting edge (cycle 1 = the cycle after that edge). busy is high for k+1 cycles.
- start while busy (SHIFT or DONE) is ignored with no queuing. Back-to-back commands are possible at best one every k+2 cycles.
- result changes only on entry to DONE. Between commands it holds the last value.
- Operand inputs are sampled only at acceptance. Changes to them during SHIFT have no effect.

Test Plan:
- Reset, then SHL data_in=5, shift_amount=3 → done pulses in cycle 4 after acceptance; result=0x00000028; busy high for 4 cycles.
- SHRA data_in=0xF0000000, amt=4 → result=0xFF000000. SHR with the same operands → result=0x0F000000.
- ROR data_in=0x00000001, amt=1 → result=0x80000000. ROL 0x80000001 amt=33 (mod 32 = 1) → result=0x00000003 after 2 busy cycles.
- Distance boundaries:
  - amt=0 with any op → done in cycle 1, result=data_in.
  - SHL amt=40 → result=0, done in cycle 1.
  - SHRA 0x80000000 amt=100 → result=0xFFFFFFFF.
- Illegal op=111, data_in=0x1234 → done and illegal_op both pulse in cycle 1; result=0x00001234.
- SHL 6 by 10, with start re-asserted and data_in changed mid-SHIFT → second start ignored; result=0x00001800. Then assert clear at shift 5 of a new command → next cycle busy=0, done=0, result=0; a new command afterwards completes normally.
